// File: rtl/rd_ptr_empty_if.sv
// Read-side handshake bundle for rd_ptr_empty: consumer read request, synchronized
// write pointer in, and RAM address / Gray pointer / status flags out.
interface rd_ptr_empty_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  i_rd_en;
   logic [ADDR_WIDTH:0]   i_wptr_gray_sync;
   logic [ADDR_WIDTH-1:0] o_raddr;
   logic [ADDR_WIDTH:0]   o_rptr_gray;
   logic                  o_empty;
   logic                  o_underflow;
   logic                  o_almost_empty;

   modport master (
      output i_rd_en,
      output i_wptr_gray_sync,
      input  o_raddr,
      input  o_rptr_gray,
      input  o_empty,
      input  o_underflow,
      input  o_almost_empty
   );

   modport slave (
      input  i_rd_en,
      input  i_wptr_gray_sync,
      output o_raddr,
      output o_rptr_gray,
      output o_empty,
      output o_underflow,
      output o_almost_empty
   );
endinterface

// File: rtl/rd_ptr_empty.sv
// Async FIFO read-side pointer, registered empty flag and underflow pulse (read clock domain).
// Optional almost-empty flag is built only when RD_PTR_ALMOST_EMPTY_EN is defined.
module rd_ptr_empty #(
   parameter int ADDR_WIDTH    = 4,
   parameter int AEMPTY_THRESH = 2
) (
   input logic           clk,
   input logic           rstn,
   rd_ptr_empty_if.slave bus
);
   localparam int PW = ADDR_WIDTH + 1;

   function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] bin);
      return (bin >> 1) ^ bin;
   endfunction

   logic [PW-1:0] rbin_r;
   logic [PW-1:0] rgray_r;
   logic          empty_r;
   logic          underflow_r;
   logic [PW-1:0] rbin_next_s;
   logic [PW-1:0] rgray_next_s;
   logic          rd_ok_s;
   logic          empty_next_s;

   // Next-state pointer: advance only on an accepted read; empty compares against the same-cycle sync pointer
   always_comb begin
      rd_ok_s      = bus.i_rd_en & ~empty_r;
      rbin_next_s  = rbin_r + {{(PW-1){1'b0}}, rd_ok_s};
      rgray_next_s = bin_to_gray(rbin_next_s);
      empty_next_s = (rgray_next_s == bus.i_wptr_gray_sync);
   end

   // Read pointer, Gray pointer, empty and underflow state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rbin_r      <= {PW{1'b0}};
         rgray_r     <= {PW{1'b0}};
         empty_r     <= 1'b1;
         underflow_r <= 1'b0;
      end else begin
         rbin_r      <= rbin_next_s;
         rgray_r     <= rgray_next_s;
         empty_r     <= empty_next_s;
         underflow_r <= bus.i_rd_en & empty_r;
      end
   end

   assign bus.o_raddr     = rbin_r[ADDR_WIDTH-1:0];
   assign bus.o_rptr_gray = rgray_r;
   assign bus.o_empty     = empty_r;
   assign bus.o_underflow = underflow_r;

`ifdef RD_PTR_ALMOST_EMPTY_EN
   localparam logic [PW-1:0] AE_THRESH_C = PW'(AEMPTY_THRESH);

   function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] gray);
      logic [PW-1:0] bin;
      bin[PW-1] = gray[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   logic [PW-1:0] wbin_sync_s;
   logic [PW-1:0] fill_s;
   logic          aempty_next_s;
   logic          aempty_r;

   // Fill level seen from the read side, using the post-read pointer
   always_comb begin
      wbin_sync_s   = gray_to_bin(bus.i_wptr_gray_sync);
      fill_s        = wbin_sync_s - rbin_next_s;
      aempty_next_s = (fill_s <= AE_THRESH_C);
   end

   // Almost-empty register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aempty_r <= 1'b1;
      end else begin
         aempty_r <= aempty_next_s;
      end
   end

   assign bus.o_almost_empty = aempty_r;
`else
   assign bus.o_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Self-checking bench for rd_ptr_empty: randomized reads/writes against a count-based reference model.
module tb_rd_ptr_empty;
   localparam int AW  = 4;
   localparam int PW  = AW + 1;
   localparam int THR = 2;
`ifdef RD_PTR_ALMOST_EMPTY_EN
   localparam bit AE_EN = 1'b1;
`else
   localparam bit AE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn;
   rd_ptr_empty_if #(.ADDR_WIDTH(AW)) bus ();

   rd_ptr_empty #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(THR)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain read/write counts, flags derived from their difference
   int m_rcnt;
   int m_wcnt;
   bit m_empty;
   bit m_under;
   bit m_aempty;

   function automatic logic [PW-1:0] to_gray(input int cnt);
      logic [PW-1:0] b;
      b = cnt[PW-1:0];
      return b ^ (b >> 1);
   endfunction

   function automatic int fill_of(input int w, input int r);
      return (((w - r) % 32) + 32) % 32;
   endfunction

   task automatic model_reset();
      m_rcnt = 0; m_wcnt = 0; m_empty = 1'b1; m_under = 1'b0; m_aempty = 1'b1;
   endtask

   // One clock: drive at negedge, update model at posedge, return #1 after the edge
   task automatic step(input bit rd, input int wcnt);
      @(negedge clk);
      bus.i_rd_en = rd;
      m_wcnt = wcnt;
      bus.i_wptr_gray_sync = to_gray(wcnt);
      @(posedge clk);
      m_under = rd & m_empty;
      if (rd && !m_empty) m_rcnt++;
      m_empty  = ((m_rcnt % 32) == (m_wcnt % 32));
      m_aempty = (fill_of(m_wcnt, m_rcnt) <= THR);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rstn = 1'b0; bus.i_rd_en = 1'b1; bus.i_wptr_gray_sync = '0;
      repeat (2) @(negedge clk);
      model_reset();
      bus.i_rd_en = 1'b0;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rstn = 1'b0; bus.i_rd_en = 1'b1; bus.i_wptr_gray_sync = '0;
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (bus.o_empty !== 1'b1 || bus.o_raddr !== 4'd0 || bus.o_rptr_gray !== 5'b00000 ||
             bus.o_underflow !== 1'b0 || bus.o_almost_empty !== AE_EN) begin
            n_fail++;
            $display("FAIL reset_hold: empty=%b raddr=%0d gray=%b under=%b ae=%b, required 1 0 00000 0 %b",
                     bus.o_empty, bus.o_raddr, bus.o_rptr_gray, bus.o_underflow, bus.o_almost_empty, AE_EN);
         end
      end
      model_reset();
      bus.i_rd_en = 1'b0;
      rstn = 1'b1;
   endtask

   task automatic test_basic_read();
      logic [PW-1:0] exp_gray [3];
      logic [AW-1:0] exp_addr [3];
      logic          exp_emp  [3];
      exp_gray = '{5'b00000, 5'b00001, 5'b00011};
      exp_addr = '{4'd0, 4'd1, 4'd2};
      exp_emp  = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         step(i != 0, 2);
         n_tests++;
         if (bus.o_raddr !== exp_addr[i] || bus.o_rptr_gray !== exp_gray[i] || bus.o_empty !== exp_emp[i]) begin
            n_fail++;
            $display("FAIL basic_read[%0d]: raddr=%0d gray=%b empty=%b, required %0d %b %b",
                     i, bus.o_raddr, bus.o_rptr_gray, bus.o_empty, exp_addr[i], exp_gray[i], exp_emp[i]);
         end
      end
   endtask

   task automatic test_underflow();
      logic [AW-1:0] addr0;
      addr0 = m_rcnt[AW-1:0];
      step(1'b1, m_wcnt);
      n_tests++;
      if (bus.o_underflow !== 1'b1 || bus.o_raddr !== addr0 || bus.o_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_pulse: under=%b raddr=%0d empty=%b, required 1 %0d 1",
                  bus.o_underflow, bus.o_raddr, bus.o_empty, addr0);
      end
      step(1'b0, m_wcnt);
      n_tests++;
      if (bus.o_underflow !== 1'b0 || bus.o_raddr !== addr0) begin
         n_fail++;
         $display("FAIL underflow_clear: under=%b raddr=%0d, required 0 %0d", bus.o_underflow, bus.o_raddr, addr0);
      end
   endtask

   task automatic test_wrap();
      logic [PW-1:0] prev;
      bit wrapped = 1'b0;
      for (int i = 0; i < 45; i++) begin
         prev = bus.o_rptr_gray;
         step(1'b1, m_rcnt + 4);
         if ((m_rcnt % 32) == 0 && m_rcnt > 0) wrapped = 1'b1;
         n_tests++;
         if (bus.o_raddr !== m_rcnt[AW-1:0] || bus.o_rptr_gray !== to_gray(m_rcnt) ||
             bus.o_empty !== m_empty || $countones(prev ^ bus.o_rptr_gray) > 1) begin
            n_fail++;
            $display("FAIL wrap[%0d]: raddr=%0d gray=%b prev=%b empty=%b, required %0d %b %b",
                     i, bus.o_raddr, bus.o_rptr_gray, prev, bus.o_empty, m_rcnt[AW-1:0], to_gray(m_rcnt), m_empty);
         end
      end
      n_tests++;
      if (!wrapped) begin
         n_fail++;
         $display("FAIL wrap_reached: read count %0d, required a pass through 32", m_rcnt);
      end
   endtask

   task automatic test_random();
      logic [PW-1:0] prev;
      bit rd;
      int w;
      for (int i = 0; i < 300; i++) begin
         rd = ($urandom_range(0, 9) < 6);
         w  = m_wcnt;
         if ((m_wcnt - m_rcnt) < 16 && $urandom_range(0, 1) == 1) w = m_wcnt + 1;
         prev = bus.o_rptr_gray;
         step(rd, w);
         n_tests++;
         if (bus.o_raddr !== m_rcnt[AW-1:0] || bus.o_rptr_gray !== to_gray(m_rcnt) ||
             bus.o_empty !== m_empty || bus.o_underflow !== m_under ||
             bus.o_almost_empty !== (AE_EN & m_aempty) || $countones(prev ^ bus.o_rptr_gray) > 1) begin
            n_fail++;
            $display("FAIL random[%0d]: raddr=%0d gray=%b empty=%b under=%b ae=%b, required %0d %b %b %b %b",
                     i, bus.o_raddr, bus.o_rptr_gray, bus.o_empty, bus.o_underflow, bus.o_almost_empty,
                     m_rcnt[AW-1:0], to_gray(m_rcnt), m_empty, m_under, AE_EN & m_aempty);
         end
      end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      apply_reset();
      while ((m_rcnt % 32) != 7 && guard < 40) begin
         step(1'b1, m_rcnt + 3);
         guard++;
      end
      n_tests++;
      if (bus.o_raddr !== 4'd7) begin
         n_fail++;
         $display("FAIL async_setup: raddr=%0d, required 7", bus.o_raddr);
      end
      bus.i_rd_en = 1'b1;
      #2 rstn = 1'b0;
      #1;
      n_tests++;
      if (bus.o_raddr !== 4'd0 || bus.o_rptr_gray !== 5'b00000 || bus.o_empty !== 1'b1 ||
          bus.o_underflow !== 1'b0 || bus.o_almost_empty !== AE_EN) begin
         n_fail++;
         $display("FAIL async_reset: raddr=%0d gray=%b empty=%b under=%b ae=%b, required 0 00000 1 0 %b",
                  bus.o_raddr, bus.o_rptr_gray, bus.o_empty, bus.o_underflow, bus.o_almost_empty, AE_EN);
      end
      @(negedge clk);
      model_reset();
      bus.i_rd_en = 1'b0; bus.i_wptr_gray_sync = '0;
      rstn = 1'b1;
      step(1'b0, 3);
      step(1'b1, 3);
      n_tests++;
      if (bus.o_raddr !== 4'd1 || bus.o_rptr_gray !== 5'b00001 || bus.o_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL async_resume: raddr=%0d gray=%b empty=%b, required 1 00001 0",
                  bus.o_raddr, bus.o_rptr_gray, bus.o_empty);
      end
   endtask

   task automatic test_almost_empty();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         step(i != 0, 4);
         n_tests++;
         if (bus.o_almost_empty !== (AE_EN & m_aempty) || bus.o_empty !== m_empty) begin
            n_fail++;
            $display("FAIL almost_empty[%0d]: ae=%b empty=%b, required %b %b",
                     i, bus.o_almost_empty, bus.o_empty, AE_EN & m_aempty, m_empty);
         end
      end
      n_tests++;
      if (bus.o_empty !== 1'b1 || bus.o_raddr !== 4'd4) begin
         n_fail++;
         $display("FAIL almost_empty_drain: empty=%b raddr=%0d, required 1 4", bus.o_empty, bus.o_raddr);
      end
   endtask

   initial begin
      rstn = 1'b1;
      bus.i_rd_en = 1'b0;
      bus.i_wptr_gray_sync = '0;
      model_reset();
      test_reset();
      test_basic_read();
      test_underflow();
      test_wrap();
      test_random();
      test_async_reset();
      test_almost_empty();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
